// File: rtl/guess_solver.sv
// Binary-search player for guess_game: drives a guess, waits for the response to
// settle, narrows [lo, hi] until the game reports correct or the try limit is hit.
module guess_solver #(
  parameter int WIDTH     = 6,
  parameter int SETTLE    = 2,
  parameter int MAX_TRIES = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [3:0]       tries
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_EVAL,
    S_DONE,
    S_FAIL
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lo_q, hi_q, guess_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       tries_q;
  logic             busy_q, done_q, found_q;

  // Midpoint is formed one bit wider so lo+hi cannot wrap.
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] mid_d;
  logic             at_limit_d;
  logic             unused_result_hi;

  assign sum_d            = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid_d            = sum_d[WIDTH:1];
  assign at_limit_d       = (tries_q == 4'(MAX_TRIES));
  assign unused_result_hi = ^result[WIDTH-1:3];

  // NOTE: all state updates use <= so every branch reads the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '1;
      guess_q <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            lo_q    <= '0;
            hi_q    <= '1;
            tries_q <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          guess_q <= mid_d;
          tries_q <= tries_q + 4'd1;
          cnt_q   <= CW'(SETTLE - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_EVAL;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_EVAL: begin
          case (result[2:0])
            3'b001: begin
              found_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
            3'b010: begin
              if (guess_q == lo_q || at_limit_d) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_FAIL;
              end else begin
                hi_q    <= guess_q - ONE;
                state_q <= S_DRIVE;
              end
            end
            3'b100: begin
              if (guess_q == hi_q || at_limit_d) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_FAIL;
              end else begin
                lo_q    <= guess_q + ONE;
                state_q <= S_DRIVE;
              end
            end
            default: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FAIL;
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign guess = guess_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign tries = tries_q;

endmodule

// File: tb/tb_guess_solver.sv
// Directed bench for guess_solver: a behavioural game responder answers each guess
// and the observed guess sequence and final flags are compared with hand-worked values.
module tb_guess_solver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] result;
  logic [5:0] guess;
  logic       busy, done, found;
  logic [3:0] tries;

  logic [5:0] target;
  int         mode;       // 0 honest, 1 always too low, 2 answers 000, 3 answers 011

  int vectors     = 0;
  int miscompares = 0;
  int obs_q[$];
  int cyc_q[$];
  bit timed_out;

  guess_solver #(.WIDTH(6), .SETTLE(2), .MAX_TRIES(7)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .result (result),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .tries  (tries)
  );

  always #5 clk = ~clk;

  // Upper result bits carry junk the solver must ignore.
  always_comb begin
    result = 6'b101_000;
    case (mode)
      0: begin
        if (guess == target)     result[2:0] = 3'b001;
        else if (guess > target) result[2:0] = 3'b010;
        else                     result[2:0] = 3'b100;
      end
      1:       result[2:0] = 3'b100;
      2:       result[2:0] = 3'b000;
      default: result[2:0] = 3'b011;
    endcase
  end

  // Runs one search and records each new guess with the cycle it appeared on.
  task automatic play(input logic [5:0] tgt, input int md, input bit poke);
    int         cyc;
    logic [3:0] prev;
    target = tgt;
    mode   = md;
    obs_q.delete();
    cyc_q.delete();
    timed_out = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prev = tries;
    cyc  = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (tries != prev && tries != 4'd0) begin
        obs_q.push_back(int'(guess));
        cyc_q.push_back(cyc);
      end
      prev  = tries;
      start = poke && (cyc == 6 || cyc == 13);
      if (cyc > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 0; target = 6'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({guess, busy, done, found, tries} !== {6'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: guess=%0d busy=%0b done=%0b found=%0b tries=%0d, want all 0",
               guess, busy, done, found, tries);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || guess !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%0b guess=%0d, want 0/0", busy, guess);
    end
  endtask

  task automatic test_target_42();
    int exp[$] = '{31, 47, 39, 43, 41, 42};
    play(6'd42, 0, 1'b0);
    vectors++;
    if (timed_out || obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL t42_len: %0d guesses (timeout=%0b), want %0d", obs_q.size(), timed_out, exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL t42_guess%0d: got %0d, want %0d", i, obs_q[i], exp[i]);
      end
    end
    vectors++;
    if (cyc_q.size() > 0 && cyc_q[0] !== 1) begin
      miscompares++;
      $display("FAIL t42_first_latency: first guess at cycle %0d, want 1", cyc_q[0]);
    end
    for (int i = 1; i < cyc_q.size(); i++) begin
      vectors++;
      if (cyc_q[i] - cyc_q[i-1] !== 4) begin
        miscompares++;
        $display("FAIL t42_period%0d: %0d cycles, want 4", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
    vectors++;
    if ({found, done, busy, tries, guess} !== {1'b1, 1'b1, 1'b0, 4'd6, 6'd42}) begin
      miscompares++;
      $display("FAIL t42_final: found=%0b done=%0b busy=%0b tries=%0d guess=%0d, want 1 1 0 6 42",
               found, done, busy, tries, guess);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, found, tries, guess} !== {1'b1, 1'b1, 4'd6, 6'd42}) begin
      miscompares++;
      $display("FAIL t42_hold: done=%0b found=%0b tries=%0d guess=%0d, want 1 1 6 42",
               done, found, tries, guess);
    end
  endtask

  task automatic test_target_0();
    int exp[$] = '{31, 15, 7, 3, 1, 0};
    play(6'd0, 0, 1'b0);
    vectors++;
    if (timed_out || obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL t0_len: %0d guesses (timeout=%0b), want %0d", obs_q.size(), timed_out, exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL t0_guess%0d: got %0d, want %0d", i, obs_q[i], exp[i]);
      end
    end
    vectors++;
    if ({found, done, tries, guess} !== {1'b1, 1'b1, 4'd6, 6'd0}) begin
      miscompares++;
      $display("FAIL t0_final: found=%0b done=%0b tries=%0d guess=%0d, want 1 1 6 0",
               found, done, tries, guess);
    end
  endtask

  task automatic test_target_63();
    int exp[$] = '{31, 47, 55, 59, 61, 62, 63};
    play(6'd63, 0, 1'b0);
    vectors++;
    if (timed_out || obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL t63_len: %0d guesses (timeout=%0b), want %0d", obs_q.size(), timed_out, exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL t63_guess%0d: got %0d, want %0d", i, obs_q[i], exp[i]);
      end
    end
    vectors++;
    if ({found, done, tries, guess} !== {1'b1, 1'b1, 4'd7, 6'd63}) begin
      miscompares++;
      $display("FAIL t63_final: found=%0b done=%0b tries=%0d guess=%0d, want 1 1 7 63",
               found, done, tries, guess);
    end
  endtask

  task automatic test_always_low();
    int exp[$] = '{31, 47, 55, 59, 61, 62, 63};
    play(6'd0, 1, 1'b0);
    vectors++;
    if (timed_out || obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL low_len: %0d guesses (timeout=%0b), want %0d", obs_q.size(), timed_out, exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL low_guess%0d: got %0d, want %0d", i, obs_q[i], exp[i]);
      end
    end
    vectors++;
    if ({found, done, busy, tries, guess} !== {1'b0, 1'b1, 1'b0, 4'd7, 6'd63}) begin
      miscompares++;
      $display("FAIL low_final: found=%0b done=%0b busy=%0b tries=%0d guess=%0d, want 0 1 0 7 63",
               found, done, busy, tries, guess);
    end
  endtask

  task automatic test_bad_result();
    for (int md = 2; md <= 3; md++) begin
      play(6'd10, md, 1'b0);
      vectors++;
      if (timed_out || obs_q.size() !== 1) begin
        miscompares++;
        $display("FAIL bad%0d_len: %0d guesses (timeout=%0b), want 1", md, obs_q.size(), timed_out);
      end
      vectors++;
      if ({found, done, busy, tries, guess} !== {1'b0, 1'b1, 1'b0, 4'd1, 6'd31}) begin
        miscompares++;
        $display("FAIL bad%0d_final: found=%0b done=%0b busy=%0b tries=%0d guess=%0d, want 0 1 0 1 31",
                 md, found, done, busy, tries, guess);
      end
    end
  endtask

  task automatic test_reset_midsearch();
    int exp[$] = '{31, 47, 39, 43, 41, 42};
    int cyc = 0;
    target = 6'd42; mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (tries != 4'd3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (tries !== 4'd3 || guess !== 6'd39) begin
      miscompares++;
      $display("FAIL mid_reach3: tries=%0d guess=%0d, want 3/39", tries, guess);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({guess, busy, done, found, tries} !== {6'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: guess=%0d busy=%0b done=%0b found=%0b tries=%0d, want all 0",
               guess, busy, done, found, tries);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_beats_start: busy=%0b, want 0", busy);
    end
    play(6'd42, 0, 1'b1);
    vectors++;
    if (timed_out || obs_q.size() !== exp.size()) begin
      miscompares++;
      $display("FAIL rerun_len: %0d guesses (timeout=%0b), want %0d", obs_q.size(), timed_out, exp.size());
    end
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rerun_guess%0d: got %0d, want %0d", i, obs_q[i], exp[i]);
      end
    end
    vectors++;
    if ({found, done, tries, guess} !== {1'b1, 1'b1, 4'd6, 6'd42}) begin
      miscompares++;
      $display("FAIL rerun_final: found=%0b done=%0b tries=%0d guess=%0d, want 1 1 6 42",
               found, done, tries, guess);
    end
  endtask

  initial begin
    test_reset();
    test_target_42();
    test_target_0();
    test_target_63();
    test_always_low();
    test_bad_result();
    test_reset_midsearch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
